wrr_arbiter: RTL and testbench

Parametrised weighted round-robin arbiter with registered, burst-holding grants. Each port wins a burst of up to its programmed weight in consecutive cycles. Priority then rotates to the port after the previous owner. The block sits between NUM_PORTS requesters and one shared resource. It succeeds the single-cycle round-robin arbiter: it adds per-port weights, grant hold, early release and zero-bubble handover.

---
 rtl/wrr_arbiter.sv | 106 ++++++++++
 tb/tb_wrr_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with registered grants, burst hold,
// early release on request drop and zero-bubble handover.
module wrr_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int WEIGHT_W  = 4,
    localparam int IDX_W    = $clog2(NUM_PORTS)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_PORTS-1:0]          req_i,
    input  logic [NUM_PORTS*WEIGHT_W-1:0] weight_i,
    output logic [NUM_PORTS-1:0]          gnt_o,
    output logic [IDX_W-1:0]              gnt_idx_o,
    output logic                          gnt_valid_o
);

    typedef enum logic {IDLE, GRANT} state_e;

    state_e                 state_q, state_d;
    logic [NUM_PORTS-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [WEIGHT_W-1:0]    credit_q, credit_d;

    logic [IDX_W-1:0]       nxt_idx;
    logic [IDX_W-1:0]       scan_start;
    logic [IDX_W-1:0]       sel_idx;
    logic                   sel_found;
    logic [WEIGHT_W-1:0]    sel_wt;
    logic                   release_c;
    logic [WEIGHT_W-1:0]    wt [NUM_PORTS];

    always_comb begin
        for (int k = 0; k < NUM_PORTS; k++) begin
            wt[k] = weight_i[k*WEIGHT_W +: WEIGHT_W];
        end
    end

    always_comb begin
        nxt_idx    = (idx_q == IDX_W'(NUM_PORTS-1)) ? '0 : idx_q + 1'b1;
        release_c  = (state_q == GRANT) &&
                     (!req_i[idx_q] || credit_q == WEIGHT_W'(1));
        scan_start = release_c ? nxt_idx : ptr_q;
    end

    // Scan a doubled index range downward so the last hit is the first
    // requester at or after scan_start, with wrap-around.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 2*NUM_PORTS-1; i >= 0; i--) begin
            if (req_i[i % NUM_PORTS] && i >= int'(scan_start)) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i % NUM_PORTS);
            end
        end
        sel_wt = (wt[sel_idx] == '0) ? WEIGHT_W'(1) : wt[sel_idx];
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        idx_d    = idx_q;
        ptr_d    = ptr_q;
        credit_d = credit_q;
        if (state_q == IDLE || release_c) begin
            if (release_c) begin
                ptr_d = nxt_idx;
            end
            if (sel_found) begin
                state_d  = GRANT;
                gnt_d    = NUM_PORTS'(1) << sel_idx;
                idx_d    = sel_idx;
                credit_d = sel_wt;
            end else begin
                state_d  = IDLE;
                gnt_d    = '0;
                idx_d    = '0;
                credit_d = '0;
            end
        end else begin
            credit_d = credit_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            idx_q    <= '0;
            ptr_q    <= '0;
            credit_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            idx_q    <= idx_d;
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_idx_o   = idx_q;
    assign gnt_valid_o = |gnt_q;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed and random checks of wrr_arbiter against a behavioural
// model of owner, remaining credit and rotation start.
module tb_wrr_arbiter;

    localparam int NP = 4;
    localparam int WW = 4;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NP-1:0]     req_i;
    logic [NP*WW-1:0]  weight_i;
    logic [NP-1:0]     gnt_o;
    logic [IW-1:0]     gnt_idx_o;
    logic              gnt_valid_o;

    int checks = 0;
    int errors = 0;

    int m_owner;
    int m_credit;
    int m_ptr;

    wrr_arbiter #(.NUM_PORTS(NP), .WEIGHT_W(WW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_i       (req_i),
        .weight_i    (weight_i),
        .gnt_o       (gnt_o),
        .gnt_idx_o   (gnt_idx_o),
        .gnt_valid_o (gnt_valid_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [NP-1:0] r, input int start);
        for (int i = 0; i < NP; i++) begin
            if (r[(start + i) % NP]) return (start + i) % NP;
        end
        return -1;
    endfunction

    function automatic int wof(input logic [NP*WW-1:0] w, input int k);
        int v;
        v = int'(w[k*WW +: WW]);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic model_reset();
        m_owner  = -1;
        m_credit = 0;
        m_ptr    = 0;
    endtask

    task automatic model_edge();
        int k;
        bit rel;
        rel = 1'b0;
        if (m_owner >= 0) begin
            if (!req_i[m_owner] || m_credit == 1) rel = 1'b1;
            else m_credit = m_credit - 1;
        end
        if (rel) m_ptr = (m_owner + 1) % NP;
        if (m_owner < 0 || rel) begin
            k = pick(req_i, m_ptr);
            m_owner  = k;
            m_credit = (k >= 0) ? wof(weight_i, k) : 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [NP-1:0] eg;
        eg = (m_owner >= 0) ? NP'(1) << m_owner : '0;
        chk({tag, ".gnt"}, 32'(gnt_o), 32'(eg));
        chk({tag, ".idx"}, 32'(gnt_idx_o),
            32'((m_owner >= 0) ? m_owner : 0));
        chk({tag, ".valid"}, 32'(gnt_valid_o), 32'(m_owner >= 0));
        chk({tag, ".onehot0"}, 32'($onehot0(gnt_o)), 32'(1));
        chk({tag, ".shape"}, 32'(gnt_o),
            32'(NP'(gnt_valid_o) << gnt_idx_o));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        #1;
        check_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int seq [7] = '{0, 0, 1, 2, 2, 2, 3};
        int cnt;

        reset_n  = 1'b0;
        req_i    = 4'hF;
        weight_i = 16'h0312;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs("in_reset");
        chk("in_reset.const", 32'(gnt_o), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            step("rot");
            chk("rot.seq", 32'(gnt_idx_o), 32'(seq[i % 7]));
            chk("rot.nobubble", 32'(gnt_valid_o), 32'(1));
        end

        do_reset();
        weight_i = 16'h0050;
        req_i    = 4'b0110;
        step("early1");
        step("early2");
        step("early3");
        chk("early.last1", 32'(gnt_o), 32'h2);
        req_i = 4'b0100;
        step("early4");
        chk("early.handover", 32'(gnt_o), 32'h4);

        do_reset();
        weight_i = 16'h3000;
        req_i    = 4'b1000;
        for (int i = 0; i < 12; i++) begin
            step("sole");
            chk("sole.const", 32'(gnt_o), 32'h8);
        end

        do_reset();
        weight_i = 16'h0004;
        req_i    = 4'b0011;
        step("wchg1");
        weight_i = 16'h0001;
        cnt = 1;
        for (int i = 0; i < 4; i++) begin
            step("wchg");
            if (gnt_o == 4'b0001) cnt++;
        end
        chk("wchg.burst", 32'(cnt), 32'd4);
        chk("wchg.next", 32'(gnt_o), 32'h2);

        do_reset();
        weight_i = 16'h0300;
        req_i    = 4'b0100;
        step("arst1");
        step("arst2");
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_outputs("arst");
        chk("arst.gnt0", 32'(gnt_o), 32'h0);
        req_i = 4'b0101;
        @(negedge clk);
        reset_n = 1'b1;
        step("arst_after");
        chk("arst.port0", 32'(gnt_o), 32'h1);

        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 4) req_i = NP'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) weight_i = 16'($urandom);
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
